// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: issues sequential fetches to an in-order memory,
// queues returned instructions with their PCs and presents one per cycle to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        keep,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fpc;
  logic [31:0] rpc;
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        count;
  cnt_t        outst;
  cnt_t        drop;

  logic [CW:0] inflight;
  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;

  // Queued plus outstanding is capped at DEPTH, so a response always has room.
  always_comb begin
    inflight  = {1'b0, count} + {1'b0, outst};
    imem_req  = !rst && !jump && (inflight < (CW+1)'(DEPTH));
    imem_addr = fpc;
    grant     = imem_req && imem_gnt;
    resp      = imem_rvalid && (outst != '0);
    push      = resp && !jump && (drop == '0);
    valid     = !rst && (count != '0);
    pop       = valid && !keep && !jump;
    instr     = valid ? q_instr[head] : 32'h0;
    pc        = valid ? q_pc[head]    : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= RESET_PC;
      rpc   <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      outst <= '0;
      drop  <= '0;
    end else if (jump) begin
      // Every request still in flight belongs to the abandoned stream.
      head  <= tail;
      count <= '0;
      fpc   <= target;
      rpc   <= target;
      outst <= outst - cnt_t'(resp);
      drop  <= outst - cnt_t'(resp);
    end else begin
      if (grant)
        fpc <= fpc + 32'd4;
      outst <= outst + cnt_t'(grant) - cnt_t'(resp);
      if (resp && (drop != '0))
        drop <= drop - cnt_t'(1);
      if (push) begin
        tail <= tail + ptr_t'(1);
        rpc  <= rpc + 32'd4;
      end
      if (pop)
        head <= head + ptr_t'(1);
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[tail]    <= rpc;
      q_instr[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based model
// of the prefetch rules and an in-order, variable-latency memory.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, jump, keep, valid;
  logic [31:0] imem_addr, imem_rdata, target, instr, pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .jump(jump), .target(target), .keep(keep),
    .valid(valid), .instr(instr), .pc(pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int rdy; } pend_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  ent_t        mq[$];
  pend_t       pend[$];
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] m_rpc = RESET_PC;
  int          m_outst = 0;
  int          m_drop  = 0;
  int          last_rdy = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] mem_key = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic j, input logic k, input logic g,
                      input logic [31:0] t);
    logic        rv, exp_valid, exp_req, gr;
    logic [31:0] rdat;
    ent_t        e;
    pend_t       p;
    int          lat;
    rst = r; jump = j; keep = k; imem_gnt = g; target = t;
    rv   = !r && (pend.size() > 0) && (pend[0].rdy <= cyc);
    rdat = rv ? mem_data(pend[0].addr) : 32'hDEAD_BEEF;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
    exp_valid = !r && (mq.size() > 0);
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("pc",    pc,    exp_valid ? mq[0].pc  : 32'h0);
    chk("instr", instr, exp_valid ? mq[0].ins : 32'h0);
    exp_req = !r && !j && ((mq.size() + m_outst) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_fpc);
    chk("count", 32'(dut.count), 32'(mq.size()));
    chk("drop",  32'(dut.drop),  32'(m_drop));
    gr = exp_req && g;
    if (r) begin
      mq.delete(); pend.delete();
      m_fpc = RESET_PC; m_rpc = RESET_PC;
      m_outst = 0; m_drop = 0; last_rdy = cyc;
    end else begin
      if (rv) begin
        void'(pend.pop_front());
        m_outst--;
      end
      if (j) begin
        mq.delete();
        m_drop = m_outst;
        m_fpc  = t;
        m_rpc  = t;
      end else begin
        if (exp_valid && !k) void'(mq.pop_front());
        if (rv) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = m_rpc; e.ins = rdat;
            mq.push_back(e);
            m_rpc += 32'd4;
          end
        end
        if (gr) begin
          lat    = $urandom_range(lat_hi, lat_lo);
          p.addr = m_fpc;
          p.rdy  = (cyc + lat > last_rdy + 1) ? cyc + lat : last_rdy + 1;
          last_rdy = p.rdy;
          pend.push_back(p);
          m_fpc += 32'd4;
          m_outst++;
        end
      end
      chk("no_overflow", 32'(mq.size() <= DEPTH), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bit found;
    rst = 1'b1; jump = 1'b0; keep = 1'b0; imem_gnt = 1'b0; target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // Reset, then streaming with 1-cycle memory returning data = addr.
    repeat (3) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

    // Decode stall fills the queue, then drains in order.
    mem_key = 32'h5A5A_0F0F;
    repeat (3) step(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

    // Three-cycle memory with requests in flight, then redirect to 0x100.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid) begin
        found = 1'b1;
        chk("jump_first_pc", pc, 32'h100);
      end else begin
        step(0, 0, 1, 1, 0);
      end
    end
    chk("jump_seen", 32'(found), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // Redirect in the same cycle as a response and a would-be pop.
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 32'h0000_2000);
    chk("jump_resp_empty", 32'(valid), 32'd0);
    chk("jump_resp_drop", 32'(dut.drop), 32'(m_outst));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // Reset mid-stream with the queue partly full.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    chk("reset_clears_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

    // PC wrap near the top of the address space.
    step(0, 1, 0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

    // Random grant, stall, latency and occasional redirects.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 200; i++)
      step(0, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between instruction memory and the IF/ID pipeline register.
- Issues sequential fetch requests to a variable-latency, in-order instruction memory and buffers the returned instructions tagged with their PCs.
- Presents one instruction per cycle to decode, holds under decode stall, and flushes/redirects on a taken branch.
- Replaces the free-running PC register plus combinational fetch path at the front of the pipeline.

Parameters:
- DEPTH, 4, entries in the instruction queue; also the cap on queued plus outstanding requests (power of two, 2..16).
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, word aligned.
- imem_gnt  input  1  memory accepts the request this cycle; a request transfers when imem_req && imem_gnt.
- imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  input  32  response instruction.
- jump  input  1  taken branch/redirect this cycle.
- target  input  32  redirect address, sampled when jump=1.
- keep  input  1  decode stall; head entry must not be consumed.
- valid  output  1  head entry present (count>0).
- instr  output  32  head instruction; 32'h0 when valid=0.
- pc  output  32  PC of head instruction; 32'h0 when valid=0.

Behaviour:
- State:
  - fpc: next fetch address.
  - rpc: PC of the next accepted response.
  - queue: DEPTH entries of {pc, instr} with head/tail pointers and count.
  - outst: granted, unreturned requests.
  - drop: responses still to discard.
- Reset, including mid-operation: fpc=rpc=RESET_PC, count=outst=drop=0, pointers=0, so valid=0, instr=0, pc=0, imem_req=0 in the reset cycle. Instruction memory shares rst, so no pre-reset response arrives afterward.
- imem_req = !rst && !jump && (count + outst < DEPTH). imem_addr = fpc.
- Grant (imem_req && imem_gnt): fpc <= fpc+4, outst increments.
- Response:
  - Any response decrements outst.
  - If drop>0: data discarded, drop decrements.
  - Else: push {rpc, imem_rdata} at tail, rpc <= rpc+4.
  - The issue rule guarantees the queue can never overflow; a push into a full queue is a design error, and the bench asserts it never happens.
- Consume: when valid && !keep && !jump, the head is popped at the clock edge; the next entry appears the following cycle.
- Same-cycle push and pop: count unchanged, both pointers advance. A push into an empty queue becomes visible the next cycle (1 cycle rvalid-to-valid). There is no bypass.
- Jump (has priority over all other events in that cycle):
  - Queue cleared: count=0, head=tail.
  - No pop or push that cycle; a response arriving that cycle is discarded.
  - fpc <= target, rpc <= target.
  - drop <= outst minus (1 if a response arrives this cycle); outst is unchanged except for that response.
  - No request is issued in the jump cycle. The first request to target goes out the next cycle when the issue rule allows.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. fpc/rpc are 32-bit and wrap modulo 2^32 without error.
- Back-to-back jumps: each jump re-flushes. drop accumulates correctly because requests are suppressed in jump cycles.
- Throughput: with imem_gnt=1, 1-cycle latency and keep=0, one instruction per cycle is sustained after a 2-cycle startup.

Test Plan:
1. Reset release, memory returning 1 cycle after grant with data = addr, keep=0: requests at 0,4,8,... each cycle; valid rises 2 cycles after reset release with pc=0/instr=0, then pc=4, 8 on consecutive cycles.
2. keep=1 from cycle 3, DEPTH=4: queue fills to 4 with pc 0,4,8,12 (head at 0), imem_req drops to 0, head stays at 0. Release keep: pcs 0,4,8,12,16 stream out in order.
3. Memory latency 3 cycles, 3 requests outstanding, jump=1 with target=32'h100: the next valid entry has pc=0x100. The 3 stale responses are dropped and no pc from the pre-jump stream ever appears.
4. Jump in the same cycle as a response and a pop: the response is discarded, the queue is empty next cycle, and drop equals the remaining outstanding count.
5. rst asserted mid-stream with the queue half full: the next cycle has valid=0, imem_req=0. After release, fetch restarts at RESET_PC.
6. imem_gnt toggling randomly for 200 cycles plus random keep: the pc sequence at the output is strictly +4 per consumed instruction, instr matches the memory model, and count never exceeds DEPTH.
